// File: rtl/img_pkg.sv
// Shared image constants and capture FSM state type for the binarised frame store.
package img_pkg;
  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = H_ACTIVE / WORD_W;
  localparam int FRAME_WORDS    = WORDS_PER_LINE * V_ACTIVE;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} cap_state_t;
endpackage

// File: rtl/bw_word_packer.sv
// Packs accepted pixels LSB-first into WORD_W-bit words. It also issues a registered
// one-cycle strobe on the cycle after a word's last pixel is accepted.
module bw_word_packer #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              bit_i,
  input  logic              flush_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);
  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sr_q, sr_d, word_q, word_d, sr_base, sr_sh;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_base;
  logic              wv_q, wv_d;

  // flush drops the partial word; a pixel in the same cycle becomes pixel 0
  always_comb begin
    sr_base  = flush_i ? '0 : sr_q;
    cnt_base = flush_i ? '0 : cnt_q;
    sr_sh    = {bit_i, sr_base[WORD_W-1:1]};
    sr_d     = sr_base;
    cnt_d    = cnt_base;
    wv_d     = 1'b0;
    word_d   = word_q;
    if (valid_i) begin
      if (cnt_base == CW'(WORD_W-1)) begin
        wv_d   = 1'b1;
        word_d = sr_sh;
        sr_d   = '0;
        cnt_d  = '0;
      end else begin
        sr_d  = sr_sh;
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      wv_q   <= 1'b0;
      word_q <= '0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      wv_q   <= wv_d;
      word_q <= word_d;
    end
  end

  assign word_valid_o = wv_q;
  assign word_o       = word_q;
endmodule

// File: rtl/bw_frame_capture.sv
// Captures one binarised VGA frame from its origin into the 16-bit-word frame store.
// Define BW_CAPTURE_CONTINUOUS_EN to re-arm after every frame instead of returning to IDLE.
module bw_frame_capture #(
  parameter int H_ACTIVE = img_pkg::H_ACTIVE,
  parameter int V_ACTIVE = img_pkg::V_ACTIVE,
  parameter int WORD_W   = img_pkg::WORD_W,
  parameter int ADDR_W   = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [10:0]       iVGA_X,
  input  logic [10:0]       iVGA_Y,
  input  logic              VGA_Read,
  input  logic              iBW,
  input  logic              iStart,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [WORD_W-1:0] oWrData
);
  import img_pkg::*;

  localparam int FWORDS = (H_ACTIVE / WORD_W) * V_ACTIVE;

  cap_state_t        state_q, state_d;
  logic [10:0]       col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              origin, final_wr, start_frame, px_acc, wr_en;
  logic [WORD_W-1:0] wr_word;

  assign origin   = VGA_Read && (iVGA_X == '0) && (iVGA_Y == '0);
  assign final_wr = (state_q == CAPTURE) && wr_en && (wcnt_q == ADDR_W'(FWORDS-1));
  // row reaching V_ACTIVE marks the frame's last pixel as taken; later pixels are ignored
  assign start_frame = origin && ((state_q == ARM) || ((state_q == CAPTURE) && !final_wr));
  assign px_acc      = start_frame ||
                       ((state_q == CAPTURE) && VGA_Read && (row_q != 11'(V_ACTIVE)));

  bw_word_packer #(.WORD_W(WORD_W)) u_pack (
    .clk          (CLK),
    .rst_n        (RST),
    .valid_i      (px_acc),
    .bit_i        (iBW),
    .flush_i      (start_frame),
    .word_valid_o (wr_en),
    .word_o       (wr_word)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    if (wr_en) wcnt_d = wcnt_q + 1'b1;
    if (start_frame) begin
      col_d  = 11'd1;
      row_d  = '0;
      wcnt_d = '0;
    end else if (px_acc) begin
      if (col_q == 11'(H_ACTIVE-1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    case (state_q)
      IDLE: if (iStart) begin
        err_d   = 1'b0;
        state_d = ARM;
      end
      ARM:  if (origin) state_d = CAPTURE;
      CAPTURE: begin
        if (final_wr)    state_d = DONE;
        else if (origin) err_d   = 1'b1;
      end
      DONE: begin
`ifdef BW_CAPTURE_CONTINUOUS_EN
        state_d = ARM;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign oBusy   = (state_q == ARM) || (state_q == CAPTURE);
  assign oDone   = (state_q == DONE);
  assign oErr    = err_q;
  assign oWrEn   = wr_en;
  assign oWrAddr = wcnt_q;
  assign oWrData = wr_word;
endmodule

// File: tb/tb_bw_frame_capture.sv
// Randomised bench for bw_frame_capture on a reduced 64x6 frame, checked against a pixel-index model.
module tb_bw_frame_capture;
  localparam int H = 64, V = 6, W = 16, AW = 15, NPIX = H*V, WPL = H/W;
`ifdef BW_CAPTURE_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic          CLK = 1'b0, RST = 1'b1;
  logic [10:0]   iVGA_X = '0, iVGA_Y = '0;
  logic          VGA_Read = 1'b0, iBW = 1'b0, iStart = 1'b0;
  logic          oBusy, oDone, oErr, oWrEn;
  logic [AW-1:0] oWrAddr;
  logic [W-1:0]  oWrData;

  bw_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .WORD_W(W), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .iVGA_X(iVGA_X), .iVGA_Y(iVGA_Y), .VGA_Read(VGA_Read),
    .iBW(iBW), .iStart(iStart), .oBusy(oBusy), .oDone(oDone), .oErr(oErr),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, busy_in_done = 0;
  int ga[$], gc[$], dc[$], ea[$], ec[$], edc[$];
  logic [W-1:0] gd[$], ed[$];
  bit img[NPIX];
  bit m_arm = 0, m_cap = 0, m_err = 0;

  always @(negedge CLK) if (RST) begin
    if (oWrEn) begin ga.push_back(int'(oWrAddr)); gd.push_back(oWrData); gc.push_back(cyc); end
    if (oDone) dc.push_back(cyc);
    if (oDone && oBusy) busy_in_done++;
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(bit rd, int x, int y, bit b);
    @(posedge CLK); #1;
    VGA_Read = rd; iVGA_X = 11'(x); iVGA_Y = 11'(y); iBW = b; iStart = 1'b0;
  endtask

  // idle cycles carry random coordinates (often 0,0) and data that must be ignored
  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, ($urandom_range(0,2) == 0) ? 0 : $urandom_range(0,700),
            ($urandom_range(0,2) == 0) ? 0 : $urandom_range(0,500), 1'($urandom_range(0,1)));
  endtask

  // reference: word k of a frame holds raster pixels k*W..k*W+W-1, leftmost in bit 0
  task automatic model(int p);
    logic [W-1:0] d;
    if (p == 0 && (m_arm || m_cap)) begin
      if (m_cap) m_err = 1'b1;
      m_cap = 1'b1; m_arm = 1'b0;
    end
    if (m_cap && (p % W) == W-1) begin
      for (int j = 0; j < W; j++) d[j] = img[p-W+1+j];
      ea.push_back(p / W); ed.push_back(d); ec.push_back(cyc + 1);
      if (p == NPIX-1) begin
        edc.push_back(cyc + 2);
        m_cap = 1'b0; m_arm = CONT;
      end
    end
  endtask

  task automatic pix(int p, int gap);
    idle((gap < 0) ? $urandom_range(0,3) : gap);
    drive(1'b1, p % H, p / H, img[p]);
    model(p);
  endtask

  task automatic frame(int first, int last, int gap);
    for (int p = first; p <= last; p++) pix(p, gap);
  endtask

  task automatic start_cap();
    @(posedge CLK); #1;
    VGA_Read = 1'b0; iStart = 1'b1; iBW = 1'b0;
    if (!m_arm && !m_cap) begin m_arm = 1'b1; m_err = 1'b0; end
  endtask

  task automatic fill(int mode);
    for (int p = 0; p < NPIX; p++)
      case (mode)
        0:       img[p] = 1'b1;
        1:       img[p] = 1'((p % H) & 1);
        2:       img[p] = (p == 2*H + 17);
        default: img[p] = 1'($urandom_range(0,1));
      endcase
  endtask

  task automatic clrq();
    ga.delete(); gd.delete(); gc.delete(); dc.delete();
    ea.delete(); ed.delete(); ec.delete(); edc.delete();
  endtask

  task automatic compare(string tag);
    chk({tag, ".nwr"}, ga.size(), ea.size());
    for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), ga[i], ea[i]);
      chk($sformatf("%s.data%0d", tag, i), gd[i], ed[i]);
      chk($sformatf("%s.wcyc%0d", tag, i), gc[i], ec[i]);
    end
    chk({tag, ".ndone"}, dc.size(), edc.size());
    for (int i = 0; i < edc.size() && i < dc.size(); i++)
      chk($sformatf("%s.dcyc%0d", tag, i), dc[i], edc[i]);
    chk({tag, ".err"}, oErr, m_err);
    clrq();
  endtask

  initial begin
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.busy", oBusy, 0);   chk("rst.done", oDone, 0);
    chk("rst.err", oErr, 0);     chk("rst.wren", oWrEn, 0);
    chk("rst.addr", oWrAddr, 0); chk("rst.data", oWrData, 0);
    RST = 1'b1;
    idle(3);

    fill(0); clrq(); start_cap(); frame(0, NPIX-1, 0); idle(10);
    chk("white.w0", (gd.size() > 0) ? gd[0] : 'x, 16'hFFFF);
    chk("white.space", (gc.size() > 1) ? gc[1] - gc[0] : -1, W);
    compare("white");

    fill(1); start_cap(); frame(0, NPIX-1, 0); idle(10);
    chk("alt.w0", (gd.size() > 0) ? gd[0] : 'x, 16'hAAAA);
    compare("alt");

    fill(2); start_cap(); frame(0, NPIX-1, -1); idle(10);
    chk("dot.w", (gd.size() > 2*WPL+1) ? gd[2*WPL+1] : 'x, 16'h0002);
    compare("dot");

    fill(3); start_cap(); frame(0, NPIX-1, 1); idle(10);
    chk("half.space", (gc.size() > 1) ? gc[1] - gc[0] : -1, 2*W);
    compare("half");

    fill(3); start_cap(); frame(0, NPIX-1, -1); idle(10);
    compare("rand");

    // start mid-frame, then a fresh origin interrupts the capture part-way through word 10
    fill(3); frame(0, 3*H-1, 0); start_cap(); frame(3*H, NPIX-1, 0);
    frame(0, 10*W+5, 0); fill(3); frame(0, NPIX-1, -1); idle(10);
    compare("resync");
    start_cap(); idle(2);
    chk("errclr", oErr, m_err);

    // async reset lands in the write cycle of word 5
    fill(3); frame(0, 6*W-2, 0);
    drive(1'b1, (6*W-1) % H, (6*W-1) / H, img[6*W-1]);
    @(posedge CLK); #3 RST = 1'b0;
    #1;
    chk("arst.wren", oWrEn, 0); chk("arst.busy", oBusy, 0);
    chk("arst.addr", oWrAddr, 0); chk("arst.done", oDone, 0);
    m_arm = 0; m_cap = 0; m_err = 0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    idle(3); frame(0, NPIX-1, 0); idle(10);
    compare("arst");

    fill(3); start_cap(); frame(0, NPIX-1, 0); idle(8);
    fill(3); frame(0, NPIX-1, -1); idle(10);
    chk("cont.ndone", dc.size(), CONT ? 2 : 1);
    compare("cont");
    chk("busy_in_done", busy_in_done, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
